// File: rtl/pcl_unit.sv
// Program-counter low byte for the 65C02 core: increment, bus load and relative branch,
// with registered carry/borrow pulses to PCH and a one-cycle page-cross fix-up state.
module pcl_unit (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pcl_load,
   input  logic [7:0] db_in,
   input  logic       pc_inc,
   input  logic       branch_req,
   input  logic [7:0] branch_offset,
   output logic [7:0] address_low_out,
   output logic [7:0] db_out,
   output logic       carry_to_pch,
   output logic       borrow_to_pch,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      FIXUP = 1'b1
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] pcl_reg, pcl_next;
   logic       carry_reg, carry_next;
   logic       borrow_reg, borrow_next;
   logic [8:0] sum9;

   // Unsigned 9-bit add; the offset sign plus the carry-out classifies the page cross.
   assign sum9 = {1'b0, pcl_reg} + {1'b0, branch_offset};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         pcl_reg    <= 8'h00;
         carry_reg  <= 1'b0;
         borrow_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pcl_reg    <= pcl_next;
         carry_reg  <= carry_next;
         borrow_reg <= borrow_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pcl_next    = pcl_reg;
      carry_next  = 1'b0;
      borrow_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pcl_load) begin
               pcl_next = db_in;
            end else if (branch_req) begin
               pcl_next = sum9[7:0];
               if (!branch_offset[7] && sum9[8]) begin
                  carry_next = 1'b1;
                  state_next = FIXUP;
               end else if (branch_offset[7] && !sum9[8]) begin
                  borrow_next = 1'b1;
                  state_next  = FIXUP;
               end
            end else if (pc_inc) begin
               pcl_next   = pcl_reg + 8'd1;
               carry_next = (pcl_reg == 8'hFF);
            end
         end
         FIXUP: begin
            // Only a bus load is honoured here; the pulse already issued drops on exit.
            state_next = IDLE;
            if (pcl_load) begin
               pcl_next = db_in;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign address_low_out = pcl_reg;
   assign db_out          = pcl_reg;
   assign carry_to_pch    = carry_reg;
   assign borrow_to_pch   = borrow_reg;
   assign busy            = (state_reg == FIXUP);

endmodule

// File: tb/tb_pcl_unit.sv
// Directed-vector bench for pcl_unit; expected values are hand-computed per vector.
module tb_pcl_unit;

   logic       clk;
   logic       reset_n;
   logic       pcl_load;
   logic [7:0] db_in;
   logic       pc_inc;
   logic       branch_req;
   logic [7:0] branch_offset;
   logic [7:0] address_low_out;
   logic [7:0] db_out;
   logic       carry_to_pch;
   logic       borrow_to_pch;
   logic       busy;

   int n_vec;
   int n_bad;

   pcl_unit dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .pcl_load        (pcl_load),
      .db_in           (db_in),
      .pc_inc          (pc_inc),
      .branch_req      (branch_req),
      .branch_offset   (branch_offset),
      .address_low_out (address_low_out),
      .db_out          (db_out),
      .carry_to_pch    (carry_to_pch),
      .borrow_to_pch   (borrow_to_pch),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of requests, then sample 1 time unit after the edge.
   task automatic cyc(input logic ld, input logic [7:0] d, input logic inc,
                      input logic br, input logic [7:0] off);
      pcl_load      = ld;
      db_in         = d;
      pc_inc        = inc;
      branch_req    = br;
      branch_offset = off;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [7:0] pcl,
                               input logic c, input logic b, input logic bz);
      chk({tag, ".pcl"}, address_low_out, pcl);
      chk({tag, ".carry"}, {7'd0, carry_to_pch}, {7'd0, c});
      chk({tag, ".borrow"}, {7'd0, borrow_to_pch}, {7'd0, b});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
      $display("vec %-12s pcl=%02h c=%0b b=%0b busy=%0b", tag, address_low_out,
               carry_to_pch, borrow_to_pch, busy);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset_n = 1'b0;
      pcl_load = 1'b0; db_in = 8'h00; pc_inc = 1'b0;
      branch_req = 1'b0; branch_offset = 8'h00;

      #12;
      expect_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      chk("reset.db_out", db_out, 8'h00);
      reset_n = 1'b1;
      #1;

      cyc(0, 8'h00, 1, 0, 8'h00);
      cyc(0, 8'h00, 1, 0, 8'h00);
      cyc(0, 8'h00, 1, 0, 8'h00);
      expect_state("inc3", 8'h03, 1'b0, 1'b0, 1'b0);
      chk("inc3.db_out", db_out, 8'h03);

      // Increment across 0xFF
      cyc(1, 8'hFF, 0, 0, 8'h00);
      expect_state("load_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(0, 8'h00, 1, 0, 8'h00);
      expect_state("wrap", 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(0, 8'h00, 0, 0, 8'h00);
      expect_state("wrap_idle", 8'h00, 1'b0, 1'b0, 1'b0);

      // Back-to-back increments through the wrap
      cyc(1, 8'hFE, 0, 0, 8'h00);
      cyc(0, 8'h00, 1, 0, 8'h00);
      expect_state("b2b_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(0, 8'h00, 1, 0, 8'h00);
      expect_state("b2b_00", 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(0, 8'h00, 1, 0, 8'h00);
      expect_state("b2b_01", 8'h01, 1'b0, 1'b0, 1'b0);

      // Forward crossing branch; branch and inc during FIXUP are ignored
      cyc(1, 8'hF0, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 1, 8'h20);
      expect_state("fwd_cross", 8'h10, 1'b1, 1'b0, 1'b1);
      cyc(0, 8'h00, 1, 1, 8'h20);
      expect_state("fwd_fixup", 8'h10, 1'b0, 1'b0, 1'b0);

      // Forward non-crossing branch
      cyc(0, 8'h00, 0, 1, 8'h05);
      expect_state("fwd_near", 8'h15, 1'b0, 1'b0, 1'b0);

      // Backward branches
      cyc(1, 8'h05, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 1, 8'hFB);
      expect_state("bwd_near", 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1, 8'h05, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 1, 8'hFA);
      expect_state("bwd_cross", 8'hFF, 1'b0, 1'b1, 1'b1);
      cyc(0, 8'h00, 0, 0, 8'h00);
      expect_state("bwd_exit", 8'hFF, 1'b0, 1'b0, 1'b0);

      // Priority: load beats branch and inc (inc from 0xFF would carry)
      cyc(1, 8'h42, 1, 1, 8'h7F);
      expect_state("priority", 8'h42, 1'b0, 1'b0, 1'b0);

      // Load during FIXUP
      cyc(1, 8'hF0, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 1, 8'h20);
      expect_state("fix_entry", 8'h10, 1'b1, 1'b0, 1'b1);
      cyc(1, 8'h99, 0, 0, 8'h00);
      expect_state("fix_load", 8'h99, 1'b0, 1'b0, 1'b0);
      cyc(0, 8'h00, 1, 0, 8'h00);
      expect_state("after_load", 8'h9A, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset during FIXUP
      cyc(1, 8'hF0, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 1, 8'h20);
      expect_state("rst_entry", 8'h10, 1'b1, 1'b0, 1'b1);
      pcl_load = 1'b0; branch_req = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      expect_state("rst_fixup", 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      expect_state("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      cyc(0, 8'h00, 1, 0, 8'h00);
      expect_state("rst_release", 8'h01, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
